// File: rtl/uart_rx_if.sv
// Serial receive interface: line input plus received-byte status.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  modport master (output rxd, input rx_data, rx_done, rx_busy, frame_err);
  modport slave  (input rxd, output rx_data, rx_done, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized line, single mid-bit sample per bit,
// framing-error detection with a break state that waits for the line to idle.
module uart_rx #(
  parameter int unsigned CLK_FRE = 50_000_000,
  parameter int unsigned BAUD    = 115200
) (
  input  logic      clk,
  input  logic      uart_rst_n,
  uart_rx_if.slave  rx
);

  localparam int unsigned DIV  = CLK_FRE / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic        rxd_meta_q, rxd_meta_d;
  logic        rxd_s_q,    rxd_s_d;
  logic        rxd_dly_q,  rxd_dly_d;
  logic [2:0]  state_q,    state_d;
  logic [15:0] cnt_q,      cnt_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic [7:0]  shift_q,    shift_d;
  logic [7:0]  rx_data_q,  rx_data_d;
  logic        rx_done_q,  rx_done_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_busy_q,  rx_busy_d;
  logic        fall_c;

  // Synchronizer and edge-delay chain; idle level is high.
  always_comb begin
    rxd_meta_d = rx.rxd;
    rxd_s_d    = rxd_meta_q;
    rxd_dly_d  = rxd_s_q;
  end

  assign fall_c = ~rxd_s_q & rxd_dly_q;

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_c) state_d = S_START;
      end
      S_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt_q == HALF_M1) begin
          if (!rxd_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == DIV_M1) begin
          shift_d[bit_idx_q] = rxd_s_q;
          cnt_d              = '0;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == DIV_M1) begin
          if (rxd_s_q) begin
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    rx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_dly_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd_meta_d;
      rxd_s_q     <= rxd_s_d;
      rxd_dly_q   <= rxd_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_done   = rx_done_q;
  assign rx.frame_err = frame_err_q;
  assign rx.rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: default-rate instance plus a DIV=10 instance.
module tb_uart_rx;

  localparam int DIV0 = 434;
  localparam int HALF0 = 217;
  localparam int DIV1 = 10;
  localparam int HALF1 = 5;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   ferr_exp = 0;
  int   ferr_seen = 0;
  exp_t sb[$];

  logic       pd [2];
  logic       pf [2];
  logic [7:0] last [2];

  uart_rx_if if0 ();
  uart_rx_if if1 ();

  uart_rx u_dut0 (
    .clk        (clk),
    .uart_rst_n (rst_n),
    .rx         (if0.slave)
  );

  uart_rx #(.CLK_FRE(1_000_000), .BAUD(100_000)) u_dut1 (
    .clk        (clk),
    .uart_rst_n (rst_n),
    .rx         (if1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rxd(input int k, input logic v);
    if (k == 0) if0.rxd = v;
    else        if1.rxd = v;
  endtask

  function automatic logic busy_of(input int k);
    return (k == 0) ? if0.rx_busy : if1.rx_busy;
  endfunction

  // One 8N1 frame; stop_low > 0 holds the stop bit low for that many bit times.
  task automatic send(input int k, input logic [7:0] b, input int stop_low);
    int   d;
    exp_t e;
    d = (k == 0) ? DIV0 : DIV1;
    set_rxd(k, 1'b0);
    if (stop_low == 0) begin
      e.inst = k;
      e.data = b;
      e.t0   = cyc;
      sb.push_back(e);
    end else begin
      ferr_exp++;
    end
    tick(d);
    for (int i = 0; i < 8; i++) begin
      set_rxd(k, b[i]);
      tick(d);
    end
    if (stop_low > 0) begin
      set_rxd(k, 1'b0);
      tick(d * stop_low);
      chk("busy_in_break", busy_of(k), 1'b1);
      set_rxd(k, 1'b1);
      tick(d);
      chk("busy_after_break", busy_of(k), 1'b0);
    end else begin
      set_rxd(k, 1'b1);
      tick(d);
    end
  endtask

  task automatic mon(input int k, input logic done, input logic ferr,
                     input logic busy, input logic [7:0] data);
    exp_t e;
    int   lat;
    int   exp_lat;
    if (done) begin
      chk("done_width", pd[k], 1'b0);
      chk("done_ferr_excl", ferr, 1'b0);
      if (sb.size() == 0) begin
        chk("done_unexp", done, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("done_inst", k, e.inst);
        chk("rx_data", data, e.data);
        lat     = cyc - e.t0;
        exp_lat = (k == 0) ? (HALF0 + 9 * DIV0 + 3) : (HALF1 + 9 * DIV1 + 3);
        if (lat < exp_lat - 2 || lat > exp_lat + 2)
          $display("latency inst %0d: %0d cycles, window %0d+/-2", k, lat, exp_lat);
        chk("latency_window", (lat >= exp_lat - 2) && (lat <= exp_lat + 2), 1'b1);
        chk("busy_after_done", busy, 1'b0);
      end
      last[k] = data;
    end else if (data !== last[k]) begin
      chk("data_hold", data, last[k]);
      last[k] = data;
    end
    if (ferr) begin
      ferr_seen++;
      chk("ferr_width", pf[k], 1'b0);
      chk("ferr_busy", busy, 1'b1);
    end
    pd[k] = done;
    pf[k] = ferr;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        pd[k]   = 1'b0;
        pf[k]   = 1'b0;
        last[k] = 8'h00;
      end
    end else begin
      mon(0, if0.rx_done, if0.frame_err, if0.rx_busy, if0.rx_data);
      mon(1, if1.rx_done, if1.frame_err, if1.rx_busy, if1.rx_data);
    end
  end

  initial begin
    int t0;
    set_rxd(0, 1'b1);
    set_rxd(1, 1'b1);
    rst_n = 1'b0;
    tick(5);
    chk("rst_data0", if0.rx_data, 8'h00);
    chk("rst_done0", if0.rx_done, 1'b0);
    chk("rst_busy0", if0.rx_busy, 1'b0);
    chk("rst_ferr0", if0.frame_err, 1'b0);
    chk("rst_data1", if1.rx_data, 8'h00);
    chk("rst_busy1", if1.rx_busy, 1'b0);
    rst_n = 1'b1;
    tick(10);

    send(0, 8'h55, 0);
    tick(20);
    chk("data_55", if0.rx_data, 8'h55);
    chk("idle_after_55", if0.rx_busy, 1'b0);

    // Back-to-back frames: start bit follows the stop bit directly.
    send(0, 8'hA5, 0);
    send(0, 8'h3C, 0);
    tick(20);
    chk("data_3c", if0.rx_data, 8'h3C);

    // 100-cycle low glitch from idle is rejected at mid start bit.
    set_rxd(0, 1'b0);
    t0 = cyc;
    tick(100);
    set_rxd(0, 1'b1);
    tick(HALF0 + 1 - 100);
    chk("glitch_busy_hi", if0.rx_busy, 1'b1);
    tick(4);
    chk("glitch_busy_lo", if0.rx_busy, 1'b0);
    chk("glitch_data", if0.rx_data, 8'h3C);
    if (cyc - t0 != HALF0 + 5) $display("glitch timing offset %0d", cyc - t0);
    tick(20);

    send(0, 8'h12, 0);
    send(0, 8'h34, 3);
    chk("ferr_data_kept", if0.rx_data, 8'h12);
    tick(10);
    send(0, 8'h56, 0);
    tick(20);
    chk("data_56", if0.rx_data, 8'h56);

    // Reset in the middle of data bit 4 of 0xFF.
    set_rxd(0, 1'b0);
    tick(DIV0);
    set_rxd(0, 1'b1);
    tick(DIV0 * 4 + HALF0);
    rst_n = 1'b0;
    tick(3);
    chk("midrst_data", if0.rx_data, 8'h00);
    chk("midrst_done", if0.rx_done, 1'b0);
    chk("midrst_busy", if0.rx_busy, 1'b0);
    chk("midrst_ferr", if0.frame_err, 1'b0);
    rst_n = 1'b1;
    tick(DIV0 * 4);
    chk("postrst_busy", if0.rx_busy, 1'b0);
    send(0, 8'h81, 0);
    tick(20);
    chk("data_81", if0.rx_data, 8'h81);

    // Fast instance, DIV = 10.
    send(1, 8'h00, 0);
    send(1, 8'hFF, 0);
    tick(20);
    chk("data1_ff", if1.rx_data, 8'hFF);
    chk("busy1_idle", if1.rx_busy, 1'b0);

    chk("sb_empty", sb.size(), 0);
    chk("ferr_count", ferr_seen, ferr_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate in bits/s.
REQ-003 SHALL derive constant DIV = CLK_FRE/BAUD (434 at defaults) and HALF = DIV/2 (217).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port uart_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port rxd  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-008 SHALL have port rx_done  output  1  one-cycle pulse; rx_data newly valid.
REQ-009 SHALL have port rx_busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-011 SHALL pass rxd through a two-flop synchronizer; rxd_s = second flop output; all decisions use rxd_s only.
REQ-012 SHALL detect start as rxd_s low while its one-cycle-delayed copy is high (falling edge).
REQ-013 SHALL use one 16-bit clock counter cnt, zeroed on every state change, plus a 3-bit bit index.
REQ-014 SHALL implement states IDLE, START, DATA, STOP and BREAK; rx_busy = (state != IDLE).
REQ-015 IDLE: on falling edge -> START with cnt=0; otherwise stay and hold cnt=0.
REQ-016 START: at cnt==HALF-1, if rxd_s==0 -> DATA with bit index 0; if rxd_s==1 -> IDLE (false start) with no pulse on any output.
REQ-017 DATA: at cnt==DIV-1, store rxd_s into shift bit [bit index] and reset cnt; after bit index 7 -> STOP; otherwise increment bit index.
REQ-018 STOP: at cnt==DIV-1, if rxd_s==1, load rx_data from the shift register, pulse rx_done for exactly one cycle and go to IDLE.
REQ-019 STOP: at cnt==DIV-1, if rxd_s==0, pulse frame_err for one cycle, leave rx_data unchanged, and go to BREAK.
REQ-020 BREAK: remain until rxd_s==1, then -> IDLE; no start detection while in BREAK.
REQ-021 rx_done and frame_err SHALL never assert in the same cycle, and neither SHALL assert for more than one consecutive cycle.
REQ-022 rx_data SHALL change only in the rx_done cycle and SHALL hold its value between frames.
REQ-023 Latency: rx_done SHALL assert HALF+9*DIV+3 cycles (+/-2) after rxd falls at the start bit.
REQ-024 A falling edge occurring in the same cycle as the STOP-to-IDLE transition SHALL be ignored; the next frame SHALL be accepted from the following cycle (back-to-back frames with 1 stop bit supported).
REQ-025 Data is sampled once at mid-bit; no oversampling or majority vote.

Reset
REQ-026 While uart_rst_n is low, SHALL hold state=IDLE, cnt=0, bit index=0, shift=0x00, rx_data=0x00, rx_done=0, frame_err=0, rx_busy=0, and both synchronizer flops and the edge-delay flop at 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_done or frame_err; after release, reception SHALL resume on the next falling edge.

Verification
REQ-028 Send frame 0x55 at DIV=434 -> rx_data=0x55, rx_done high exactly 1 cycle at the REQ-023 latency, rx_busy low afterwards.
REQ-029 Send 0xA5, then immediately 0x3C (stop bit followed directly by start bit) -> two rx_done pulses, with rx_data=0xA5 then rx_data=0x3C.
REQ-030 Drive a rxd low glitch of 100 cycles from idle -> no rx_done, no frame_err, return to IDLE at cnt==216, rx_data unchanged.
REQ-031 After receiving 0x12, send 0x34 with stop bit held low for 3 bit times -> one frame_err pulse, rx_data stays 0x12, rx_busy high until rxd returns high; a subsequent frame 0x56 is received correctly.
REQ-032 Assert uart_rst_n low during data bit 4 of 0xFF -> all outputs at REQ-026 values, no pulse; then send 0x81 -> rx_data=0x81.
REQ-033 Use parameter override CLK_FRE=1_000_000, BAUD=100_000 (DIV=10) and send 0x00 and 0xFF -> both received correctly with latency 5+90+3 +/-2 cycles.
